// File: rtl/div_seq_param.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or unsigned per operation.
// Truncating quotient, remainder follows the dividend sign; dedicated div-by-zero/overflow flags.
module div_seq_param #(
  parameter int DW_A = 64,
  parameter int DW_B = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_signed,
  input  logic [DW_A-1:0] a,
  input  logic [DW_B-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [DW_A-1:0] quot,
  output logic [DW_B-1:0] rem,
  output logic            div_zero,
  output logic            overflow
);

  localparam int CW = $clog2(DW_A + 1);
  localparam logic [DW_A-1:0] MIN_A = {1'b1, {(DW_A-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [DW_A-1:0] qa, qa_sh, mag_a_in, q_fix;
  logic [DW_B-1:0] mag_b, mag_b_in, a_low, r_fix;
  logic [DW_B:0]   prem, prem_sh;
  logic            neg_q, neg_r, sp_zero, sp_ovf;
  logic            a_neg, b_neg, b_zero, ovf_in, ge;

  // Operand conditioning and one shift-subtract step, all combinational.
  always_comb begin
    a_neg    = is_signed & a[DW_A-1];
    b_neg    = is_signed & b[DW_B-1];
    mag_a_in = a_neg ? -a : a;
    mag_b_in = b_neg ? -b : b;
    b_zero   = (b == '0);
    ovf_in   = is_signed & (a == MIN_A) & (&b);
    prem_sh  = {prem[DW_B-1:0], qa[DW_A-1]};
    qa_sh    = {qa[DW_A-2:0], 1'b0};
    ge       = (prem_sh >= {1'b0, mag_b});
    q_fix    = neg_q ? -qa : qa;
    r_fix    = neg_r ? -prem[DW_B-1:0] : prem[DW_B-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next state is assigned a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (b_zero | ovf_in) ? FIX : ITER;
      ITER:    if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: all registered state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      qa       <= '0;
      prem     <= '0;
      mag_b    <= '0;
      a_low    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      sp_zero  <= 1'b0;
      sp_ovf   <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          qa      <= mag_a_in;
          mag_b   <= mag_b_in;
          prem    <= '0;
          cnt     <= CW'(DW_A);
          a_low   <= a[DW_B-1:0];
          neg_q   <= a_neg ^ b_neg;
          neg_r   <= a_neg;
          sp_zero <= b_zero;
          sp_ovf  <= ovf_in & ~b_zero;
        end
        ITER: begin
          cnt <= cnt - CW'(1);
          if (ge) begin
            prem <= prem_sh - {1'b0, mag_b};
            qa   <= qa_sh | DW_A'(1);
          end else begin
            prem <= prem_sh;
            qa   <= qa_sh;
          end
        end
        FIX: begin
          if (sp_zero) begin
            quot     <= '1;
            rem      <= a_low;
            div_zero <= 1'b1;
            overflow <= 1'b0;
          end else if (sp_ovf) begin
            quot     <= MIN_A;
            rem      <= '0;
            div_zero <= 1'b0;
            overflow <= 1'b1;
          end else begin
            quot     <= q_fix;
            rem      <= r_fix;
            div_zero <= 1'b0;
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_param.sv
// Self-checking bench for div_seq_param (DW_A=64, DW_B=32): directed vector table,
// handshake/reset sequences, and back-to-back random operations against a behavioural model.
module tb_div_seq_param;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk, rst_n, start, is_signed;
  logic [63:0] a;
  logic [31:0] b;
  logic        busy, done, div_zero, overflow;
  logic [63:0] quot;
  logic [31:0] rem;

  int n_cmp = 0;
  int n_bad = 0;

  div_seq_param #(.DW_A(64), .DW_B(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .quot(quot), .rem(rem),
    .div_zero(div_zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          sgn;
    logic [63:0] a;
    logic [31:0] b;
    logic [63:0] q;
    logic [31:0] r;
    bit          dz;
    bit          ov;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Independent reference using the language's own truncating division.
  function automatic void model(input bit sgn, input logic [63:0] av, input logic [31:0] bv,
                                output logic [63:0] q, output logic [31:0] r,
                                output bit dz, output bit ov);
    longint      sa, sb, sq, sr;
    logic [63:0] ub;
    dz = 1'b0;
    ov = 1'b0;
    if (bv == 32'd0) begin
      dz = 1'b1; q = ONES64; r = av[31:0];
    end else if (sgn && av == MIN64 && bv == 32'hFFFF_FFFF) begin
      ov = 1'b1; q = MIN64; r = 32'd0;
    end else if (sgn) begin
      sa = av;
      sb = longint'($signed(bv));
      sq = sa / sb;
      sr = sa % sb;
      q  = sq;
      r  = sr[31:0];
    end else begin
      ub = {32'd0, bv};
      q  = av / ub;
      ub = av % ub;
      r  = ub[31:0];
    end
  endfunction

  // Launch one operation (inputs set one unit after an edge), count edges after E0 until done.
  task automatic run_op(input bit sgn, input logic [63:0] av, input logic [31:0] bv,
                        input bit hold, input int pulse_at, output int n);
    is_signed = sgn; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    n = 0;
    while (1) begin
      if (pulse_at > 0 && n == pulse_at - 1) begin
        start = 1'b1; is_signed = 1'b0; a = 64'd1000; b = 32'd3;
      end else if (pulse_at > 0 && n == pulse_at) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (n >= 300) begin
        check("done_timeout", 64'(n), 64'd0);
        break;
      end
    end
  endtask

  vec_t vecs[14];

  initial begin
    int          n;
    logic [63:0] eq;
    logic [31:0] er;
    bit          edz, eov;

    vecs[0]  = '{1'b1, 64'd100, 32'd7, 64'd14, 32'd2, 1'b0, 1'b0, 65};
    vecs[1]  = '{1'b1, -64'sd100, 32'd7, 64'hFFFF_FFFF_FFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 65};
    vecs[2]  = '{1'b1, 64'd100, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 32'd2, 1'b0, 1'b0, 65};
    vecs[3]  = '{1'b1, -64'sd100, 32'hFFFF_FFF9, 64'd14, 32'hFFFF_FFFE, 1'b0, 1'b0, 65};
    vecs[4]  = '{1'b1, 64'd5, 32'd0, ONES64, 32'd5, 1'b1, 1'b0, 1};
    vecs[5]  = '{1'b0, 64'd5, 32'd0, ONES64, 32'd5, 1'b1, 1'b0, 1};
    vecs[6]  = '{1'b1, MIN64, 32'hFFFF_FFFF, MIN64, 32'd0, 1'b0, 1'b1, 1};
    vecs[7]  = '{1'b0, MIN64, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 32'h8000_0000, 1'b0, 1'b0, 65};
    vecs[8]  = '{1'b0, ONES64, 32'd1, ONES64, 32'd0, 1'b0, 1'b0, 65};
    vecs[9]  = '{1'b1, 64'd7, 32'd100, 64'd0, 32'd7, 1'b0, 1'b0, 65};
    vecs[10] = '{1'b1, MIN64, 32'd1, MIN64, 32'd0, 1'b0, 1'b0, 65};
    vecs[11] = '{1'b1, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 64'd1, 32'd0, 1'b0, 1'b0, 65};
    vecs[12] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 32'd0, ONES64, 32'hFFFF_FFFB, 1'b1, 1'b0, 1};
    vecs[13] = '{1'b0, ONES64, 32'hFFFF_FFFF, 64'h0000_0001_0000_0001, 32'd0, 1'b0, 1'b0, 65};

    // Reset state
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst quot", quot, 64'd0);
    check("rst rem", 64'(rem), 64'd0);
    check("rst flags", {62'd0, div_zero, overflow}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b0, 0, n);
      check($sformatf("vec%0d latency", i), 64'(n), 64'(vecs[i].lat));
      check($sformatf("vec%0d quot", i), quot, vecs[i].q);
      check($sformatf("vec%0d rem", i), 64'(rem), 64'(vecs[i].r));
      check($sformatf("vec%0d div_zero", i), 64'(div_zero), 64'(vecs[i].dz));
      check($sformatf("vec%0d overflow", i), 64'(overflow), 64'(vecs[i].ov));
      @(posedge clk); #1;
      check($sformatf("vec%0d done_width", i), 64'(done), 64'd0);
    end

    // Second start pulse while busy must be ignored
    run_op(1'b1, 64'd100, 32'd7, 1'b0, 10, n);
    check("ignore latency", 64'(n), 64'd65);
    check("ignore quot", quot, 64'd14);
    check("ignore rem", 64'(rem), 64'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ignore no_retrigger", 64'(busy), 64'd0);

    // Asynchronous reset in mid-operation
    is_signed = 1'b0; a = 64'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst quot", quot, 64'd0);
    check("midrst rem", 64'(rem), 64'd0);
    check("midrst flags", {62'd0, div_zero, overflow}, 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b0, 64'd1000, 32'd3, 1'b0, 0, n);
    check("postrst latency", 64'(n), 64'd65);
    check("postrst quot", quot, 64'd333);
    check("postrst rem", 64'(rem), 64'd1);
    @(posedge clk); #1;

    // Back-to-back random operations with start held high
    for (int i = 0; i < 300; i++) begin
      bit          sgn;
      logic [63:0] av;
      logic [31:0] bv;
      sgn = 1'($urandom_range(0, 1));
      av  = {$urandom, $urandom};
      bv  = $urandom;
      case ($urandom_range(0, 7))
        0: bv = $urandom_range(0, 15);
        1: bv = 32'd0;
        2: begin av = MIN64; bv = 32'hFFFF_FFFF; end
        3: av = 64'($urandom_range(0, 1000));
        4: bv = 32'hFFFF_FFFF;
        default: ;
      endcase
      model(sgn, av, bv, eq, er, edz, eov);
      run_op(sgn, av, bv, 1'b1, 0, n);
      check($sformatf("rnd%0d latency", i), 64'(n), (edz | eov) ? 64'd1 : 64'd65);
      check($sformatf("rnd%0d quot", i), quot, eq);
      check($sformatf("rnd%0d rem", i), 64'(rem), 64'(er));
      check($sformatf("rnd%0d flags", i), {62'd0, div_zero, overflow}, {62'd0, edz, eov});
      @(posedge clk); #1;
      check($sformatf("rnd%0d idle_gap", i), {62'd0, busy, done}, 64'd0);
    end
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
